// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the irq_ctl interrupt controller: FSM states,
// register addresses and STATUS word layout.
package irq_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SOFT    = 2'd3;

  localparam int STAT_IRQ_BIT  = 0;
  localparam int STAT_SERV_BIT = 1;
  localparam int STAT_ID_LSB   = 8;

  // Assemble the STATUS read word; id is passed zero-extended to 8 bits.
  function automatic logic [31:0] status_word(input logic irq,
                                              input logic in_serv,
                                              input logic [7:0] id);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_IRQ_BIT]          = irq;
    w[STAT_SERV_BIT]         = in_serv;
    w[STAT_ID_LSB +: 8]      = id;
    return w;
  endfunction

endpackage

// File: rtl/irq_ctl_prio_enc.sv
// irq_prio_enc: converts a one-hot-or-zero vector into its bit index plus a
// valid flag. Lowest-index isolation is done by the caller.
module irq_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  // OR-reduce the indices of set bits; with a one-hot input this is exact.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = idx | (onehot[i] ? W'(i) : {W{1'b0}});
    end
    valid = |onehot;
  end

endmodule

// File: rtl/irq_ctl.sv
// Level-source interrupt controller with edge capture, mask, W1C pending,
// software set and a three-state request/service handshake.
// Optional macro IRQ_CTL_SYNC_EN adds a two-flop synchronizer on src_i.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_i,
  input  logic             iack,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             reg_wr,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_din,
  output logic [31:0]      reg_dout
);

  localparam logic [N_SRC-1:0] ONE  = {{(N_SRC-1){1'b0}}, 1'b1};
  localparam logic [N_SRC-1:0] ZERO = {N_SRC{1'b0}};

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] lowest;
  logic [N_SRC-1:0] set_bits;
  logic [N_SRC-1:0] clr_bits;
  logic [ID_W-1:0]  sel_id;
  logic             sel_valid;
  logic             wr_mask;
  logic             wr_pend;
  logic             wr_soft;
  logic             ack_clr;
  logic             unused_din;

`ifdef IRQ_CTL_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  // Two-flop synchronizer for asynchronous sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= ZERO;
      sync2 <= ZERO;
    end else begin
      sync1 <= src_i;
      sync2 <= sync1;
    end
  end
  assign src_s = sync2;
`else
  assign src_s = src_i;
`endif

  // Previous-value register for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= ZERO;
    else     prev <= src_s;
  end

  assign edge_det = src_s & ~prev;
  assign wr_mask  = reg_wr & (reg_addr == ADDR_MASK);
  assign wr_pend  = reg_wr & (reg_addr == ADDR_PENDING);
  assign wr_soft  = reg_wr & (reg_addr == ADDR_SOFT);
  assign ack_clr  = (state == ST_REQ) & iack;

  // Sets are OR-ed in after clears so a same-cycle set always wins.
  assign set_bits = edge_det | (wr_soft ? reg_din[N_SRC-1:0] : ZERO);
  assign clr_bits = (wr_pend ? reg_din[N_SRC-1:0] : ZERO)
                  | (ack_clr ? (ONE << irq_id) : ZERO);

  // Mask and pending registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask    <= ZERO;
      pending <= ZERO;
    end else begin
      pending <= (pending & ~clr_bits) | set_bits;
      if (wr_mask) mask <= reg_din[N_SRC-1:0];
      else         mask <= mask;
    end
  end

  assign active = pending & mask;
  assign lowest = active & (~active + ONE);

  irq_prio_enc #(
    .N (N_SRC),
    .W (ID_W)
  ) u_prio (
    .onehot (lowest),
    .idx    (sel_id),
    .valid  (sel_valid)
  );

  // Request/service FSM with registered irq and irq_id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      irq    <= 1'b0;
      irq_id <= {ID_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            irq_id <= sel_id;
            irq    <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (iack) begin
            irq   <= 1'b0;
            state <= ST_SERV;
          end else if (!active[irq_id]) begin
            irq   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SERV: begin
          irq <= 1'b0;
          if (!iack) state <= ST_IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational register read mux.
  always_comb begin
    reg_dout = 32'd0;
    case (reg_addr)
      ADDR_MASK:    reg_dout = 32'(mask);
      ADDR_PENDING: reg_dout = 32'(pending);
      ADDR_STATUS:  reg_dout = status_word(irq, state == ST_SERV, 8'(irq_id));
      default:      reg_dout = 32'd0;
    endcase
  end

  assign unused_din = ^reg_din[31:N_SRC];

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_irq_ctl;

  localparam int N = 8;
  localparam int W = 3;
`ifdef IRQ_CTL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] FULL = 32'h0000_00FF;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src_i;
  logic         iack;
  logic         irq;
  logic [W-1:0] irq_id;
  logic         reg_wr;
  logic [1:0]   reg_addr;
  logic [31:0]  reg_din;
  logic [31:0]  reg_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending/mask sets, service phase 0=idle 1=requesting 2=in service.
  logic [31:0] m_prev, m_s1, m_s2, m_pending, m_mask;
  int          m_state;
  logic        m_irq;
  int          m_id;

  irq_ctl #(.N_SRC(N), .ID_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_i    (src_i),
    .iack     (iack),
    .irq      (irq),
    .irq_id   (irq_id),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .reg_dout (reg_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

  function automatic int lowest_idx(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pending;
      2'd2:    return {23'd0, 1'b0, 8'(m_id), 6'd0, (m_state == 2), m_irq};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = 32'd0; m_s1 = 32'd0; m_s2 = 32'd0;
    m_pending = 32'd0; m_mask = 32'd0;
    m_state = 0; m_irq = 1'b0; m_id = 0;
  endtask

  task automatic model_step();
    logic [31:0] src_eff, edg, act, set_b, clr_b;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef IRQ_CTL_SYNC_EN
    src_eff = m_s2;
    m_s2 = m_s1;
    m_s1 = 32'(src_i);
`else
    src_eff = 32'(src_i);
`endif
    edg    = src_eff & ~m_prev;
    m_prev = src_eff;
    act    = m_pending & m_mask;
    clr_b  = 32'd0;
    case (m_state)
      0: if (act != 32'd0) begin m_id = lowest_idx(act); m_irq = 1'b1; m_state = 1; end
      1: begin
        if (iack) begin clr_b = 32'd1 << m_id; m_irq = 1'b0; m_state = 2; end
        else if (act[m_id] == 1'b0) begin m_irq = 1'b0; m_state = 0; end
      end
      2: if (!iack) m_state = 0;
      default: m_state = 0;
    endcase
    set_b = edg | ((reg_wr && reg_addr == 2'd3) ? (reg_din & FULL) : 32'd0);
    if (reg_wr && reg_addr == 2'd1) clr_b = clr_b | (reg_din & FULL);
    m_pending = (m_pending & ~clr_b) | set_b;
    if (reg_wr && reg_addr == 2'd0) m_mask = reg_din & FULL;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_din = d;
    tick();
    reg_wr = 1'b0; reg_din = 32'd0;
  endtask

  task automatic wait_irq(output int cyc);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; src_i = '0; iack = 1'b0; reg_wr = 1'b0; reg_addr = 2'd0; reg_din = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
    n_tests++; if (irq_id !== 3'd0) begin n_fail++; $display("FAIL rst_id: got %0d expected 0", irq_id); end
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a); #1;
      n_tests++;
      if (reg_dout !== 32'd0) begin n_fail++; $display("FAIL rst_reg%0d: got %h expected 0", a, reg_dout); end
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_service();
    int cyc;
    wr(2'd0, 32'h05);
    src_i = 8'h04; tick(); src_i = 8'h00;
    wait_irq(cyc); cyc++;
    n_tests++; if (cyc !== LAT) begin n_fail++; $display("FAIL svc_latency: got %0d expected %0d", cyc, LAT); end
    n_tests++; if (irq_id !== 3'd2) begin n_fail++; $display("FAIL svc_id: got %0d expected 2", irq_id); end
    iack = 1'b1; tick();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL svc_ack_irq: got %b expected 0", irq); end
    reg_addr = 2'd1; #1;
    n_tests++; if (reg_dout !== 32'd0) begin n_fail++; $display("FAIL svc_pending: got %h expected 0", reg_dout); end
    reg_addr = 2'd2; #1;
    n_tests++; if (reg_dout !== 32'h202) begin n_fail++; $display("FAIL svc_status_serv: got %h expected 202", reg_dout); end
    iack = 1'b0; tick();
    reg_addr = 2'd2; #1;
    n_tests++; if (reg_dout !== 32'h200) begin n_fail++; $display("FAIL svc_status_idle: got %h expected 200", reg_dout); end
  endtask

  task automatic test_priority();
    int cyc;
    wr(2'd0, 32'hFF);
    wr(2'd3, 32'h28);
    wait_irq(cyc);
    n_tests++; if (irq !== 1'b1 || irq_id !== 3'd3) begin n_fail++; $display("FAIL prio_first: got irq=%b id=%0d expected irq=1 id=3", irq, irq_id); end
    iack = 1'b1; tick(); iack = 1'b0; tick();
    wait_irq(cyc);
    n_tests++; if (irq !== 1'b1 || irq_id !== 3'd5) begin n_fail++; $display("FAIL prio_second: got irq=%b id=%0d expected irq=1 id=5", irq, irq_id); end
    iack = 1'b1; tick(); iack = 1'b0; tick();
    reg_addr = 2'd1; #1;
    n_tests++; if (reg_dout !== 32'd0) begin n_fail++; $display("FAIL prio_pending: got %h expected 0", reg_dout); end
  endtask

  task automatic test_masked();
    int cyc;
    wr(2'd0, 32'h00);
    src_i = 8'h02; tick(); src_i = 8'h00;
    repeat (LAT) tick();
    reg_addr = 2'd1; #1;
    n_tests++; if (reg_dout !== 32'h02) begin n_fail++; $display("FAIL mask_pending: got %h expected 02", reg_dout); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_low: got %b expected 0", irq); end
    wr(2'd0, 32'h02);
    cyc = 1;
    while (irq !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    n_tests++; if (cyc > 2 || irq_id !== 3'd1) begin n_fail++; $display("FAIL mask_unmask: got cycles=%0d id=%0d expected <=2 id=1", cyc, irq_id); end
    iack = 1'b1; tick(); iack = 1'b0; tick();
  endtask

  task automatic test_withdraw();
    int cyc;
    wr(2'd0, 32'h10);
    wr(2'd3, 32'h10);
    wait_irq(cyc);
    n_tests++; if (irq !== 1'b1 || irq_id !== 3'd4) begin n_fail++; $display("FAIL wd_req: got irq=%b id=%0d expected irq=1 id=4", irq, irq_id); end
    wr(2'd1, 32'h10);
    tick();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL wd_irq: got %b expected 0", irq); end
    reg_addr = 2'd2; #1;
    n_tests++; if (reg_dout !== 32'h400) begin n_fail++; $display("FAIL wd_status: got %h expected 400", reg_dout); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    wr(2'd0, 32'h04);
    src_i = 8'h04; tick(); src_i = 8'h00;
    wait_irq(cyc);
    n_tests++; if (irq_id !== 3'd2) begin n_fail++; $display("FAIL sim_id: got %0d expected 2", irq_id); end
    src_i = 8'h04; iack = 1'b1; tick(); src_i = 8'h00;
    reg_addr = 2'd1; #1;
    n_tests++; if (reg_dout !== 32'h04) begin n_fail++; $display("FAIL sim_set_wins: got %h expected 04", reg_dout); end
    tick();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL sim_serv_irq: got %b expected 0", irq); end
    iack = 1'b0; tick(); tick();
    n_tests++; if (irq !== 1'b1 || irq_id !== 3'd2) begin n_fail++; $display("FAIL sim_rereq: got irq=%b id=%0d expected irq=1 id=2", irq, irq_id); end
    iack = 1'b1; tick(); iack = 1'b0; tick();
  endtask

  task automatic test_reset_mid_serv();
    int cyc;
    wr(2'd0, 32'hFF);
    wr(2'd3, 32'h81);
    wait_irq(cyc);
    iack = 1'b1; tick();
    wr(2'd3, 32'h01);
    reg_addr = 2'd1; #1;
    n_tests++; if (reg_dout !== 32'h81) begin n_fail++; $display("FAIL rms_pending: got %h expected 81", reg_dout); end
    rst = 1'b1; #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rms_irq: got %b expected 0", irq); end
    reg_addr = 2'd1; #1;
    n_tests++; if (reg_dout !== 32'd0) begin n_fail++; $display("FAIL rms_pending_clr: got %h expected 0", reg_dout); end
    reg_addr = 2'd0; #1;
    n_tests++; if (reg_dout !== 32'd0) begin n_fail++; $display("FAIL rms_mask_clr: got %h expected 0", reg_dout); end
    reg_addr = 2'd2; #1;
    n_tests++; if (reg_dout !== 32'd0) begin n_fail++; $display("FAIL rms_status_clr: got %h expected 0", reg_dout); end
    model_reset();
    iack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 1500; c++) begin
      src_i    = 8'($urandom);
      iack     = ($urandom_range(0, 2) != 0);
      reg_wr   = ($urandom_range(0, 3) == 0);
      reg_addr = 2'($urandom_range(0, 3));
      reg_din  = $urandom;
      tick();
      n_tests++;
      if (irq !== m_irq || irq_id !== W'(m_id) || reg_dout !== model_read(reg_addr)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand_cycle%0d: got irq=%b id=%0d dout=%h expected irq=%b id=%0d dout=%h",
                   c, irq, irq_id, reg_dout, m_irq, m_id, model_read(reg_addr));
        errs++;
      end
    end
    reg_wr = 1'b0; iack = 1'b0; src_i = '0;
  endtask

  initial begin
    test_reset();
    test_service();
    test_priority();
    test_masked();
    test_withdraw();
    test_simultaneous();
    test_reset_mid_serv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 Parameter N_SRC, default 8, meaning number of interrupt sources (range 2..16).
REQ-002 Parameter ID_W, default 3, meaning width of irq_id, equal to clog2(N_SRC).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port src_i, input, N_SRC bits: level interrupt sources; a rising edge requests service.
REQ-006 Port iack, input, 1 bit: acknowledge from the pipeline control FSM; high from interrupt entry until the return.
REQ-007 Port irq, output, 1 bit: registered interrupt request to the pipeline control FSM.
REQ-008 Port irq_id, output, ID_W bits: registered identifier of the source being requested or serviced.
REQ-009 Port reg_wr, input, 1 bit: register write strobe, single cycle.
REQ-010 Port reg_addr, input, 2 bits: register select.
REQ-011 Port reg_din, input, 32 bits: write data.
REQ-012 Port reg_dout, output, 32 bits: combinational read data for reg_addr.

Function
REQ-013 Edge detection SHALL compare each source with its registered previous value; a 0->1 transition SHALL set pending[i] on the next edge.
REQ-014 Register map SHALL be as follows; all unused bits read 0.
- Address 0, MASK: read/write; bit i=1 enables source i.
- Address 1, PENDING: read; write-1-to-clear.
- Address 2, STATUS: read; bit 0=irq, bit 1=in-service, bits [ID_W+7:8]=irq_id.
- Address 3, SOFT: write-only; ones set the corresponding pending bits; reads 0.
REQ-015 FSM states SHALL be IDLE, REQ and SERV.
REQ-016 IDLE: if (pending & mask) != 0, latch the lowest set index into irq_id, set irq=1 and go to REQ; otherwise stay.
REQ-017 REQ: on iack=1, clear pending[irq_id], drop irq and go to SERV.
REQ-018 REQ: if pending[irq_id]&mask[irq_id] becomes 0 before iack (cleared or masked), drop irq and return to IDLE.
REQ-019 SERV: irq SHALL stay 0 and irq_id SHALL hold; on iack=0 (return), go to IDLE.
REQ-020 There SHALL be no nesting: new pending bits accumulate during SERV and are arbitrated in IDLE.
REQ-021 Latency, without sync: src rises before edge k, pending=1 after edge k, irq=1 after edge k+1.
REQ-022 A set and a clear of the same pending bit in one cycle SHALL resolve as set wins; this covers edge, SOFT, W1C and the REQ-017 clear.
REQ-023 SOFT writes while in REQ SHALL NOT change irq_id.

Reset
REQ-024 Asserting rst SHALL force the following at any time, including mid-REQ or mid-SERV:
- state=IDLE, irq=0, irq_id=0;
- MASK=0, PENDING=0;
- edge-detect registers and synchronizer flops=0.

Configuration
REQ-025 With macro IRQ_CTL_SYNC_EN defined, each src_i bit SHALL pass through a two-flop synchronizer before edge detection, adding exactly 2 cycles to REQ-021.
REQ-026 Without IRQ_CTL_SYNC_EN, src_i SHALL feed edge detection directly; the sources are then required to be synchronous to clk.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the register addresses (MASK=0, PENDING=1, STATUS=2, SOFT=3) and the STATUS bit positions.
REQ-028 Lowest-index priority selection SHALL be a sub-module named irq_prio_enc: combinational, with a one-hot-or-zero input, an index output and a valid output.

Verification
REQ-029 Mask, edge and service cycle: MASK=0x05; pulse src_i[2] -> irq=1 with irq_id=2 two cycles later (no sync); iack=1 -> irq=0, PENDING=0; iack=0 -> back to IDLE.
REQ-030 Priority: pending 0x28 with MASK=0xFF -> irq_id=3; after the service cycle, irq_id=5.
REQ-031 Masked source: MASK=0x00; edge on src_i[1] -> PENDING=0x02 and irq stays 0; write MASK=0x02 -> irq=1 within 2 cycles.
REQ-032 Withdraw: in REQ for id 4, write PENDING=0x10 (W1C) -> irq=0, state IDLE, no iack required.
REQ-033 Simultaneous: new src_i[2] edge in the same cycle iack clears pending[2] -> PENDING bit 2 remains 1 -> re-requested after return.
REQ-034 Reset mid-SERV: rst=1 during SERV with PENDING=0x81 -> irq=0, PENDING=0, MASK=0 immediately, without waiting for a clock edge.
